// File: rtl/aes_dec_iter_pkg.sv
// Shared AES types, byte tables and GF(2^8) helpers for the iterative
// inverse-cipher core (aes_dec_iter) and its round sub-module.
package aes_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  // Round constants; RCON[i] is the constant used when deriving round key i.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Only divisors of 10 give a whole number of cycles per block.
  function automatic bit rpc_legal(input int r);
    return (r == 1) || (r == 2) || (r == 5) || (r == 10);
  endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// Ciphertext-in / plaintext-out handshake bundle for aes_dec_iter.
// The key_load signal exists only when AES_DEC_KEY_REUSE_EN is defined.
interface aes_dec_iter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t ciphertext;
  state_t last_key;
`ifdef AES_DEC_KEY_REUSE_EN
  logic   key_load;
`endif
  logic   out_valid;
  logic   out_ready;
  state_t plaintext;
  logic   busy;

`ifdef AES_DEC_KEY_REUSE_EN
  modport slave (
    input  in_valid, ciphertext, last_key, key_load, out_ready,
    output in_ready, out_valid, plaintext, busy
  );
  modport master (
    output in_valid, ciphertext, last_key, key_load, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );
`else
  modport slave (
    input  in_valid, ciphertext, last_key, out_ready,
    output in_ready, out_valid, plaintext, busy
  );
  modport master (
    output in_valid, ciphertext, last_key, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );
`endif

endinterface

// File: rtl/aes_dec_iter_inv_round.sv
// One combinational AES-128 inverse round: steps the key back from k_{i+1}
// to k_i, then InvShiftRows, InvSubBytes, AddRoundKey(k_i) and, unless this
// is round 0, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  state_t     state_i,
  input  state_t     key_i,
  input  logic [3:0] rnd_i,
  input  logic       final_i,
  output state_t     state_o,
  output state_t     key_o
);

  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic [31:0] rot_w, sub_w;
  logic [3:0]  rcon_idx;
  logic [7:0]  rcon;
  state_t      sb, ark, mix;

  assign w4 = key_i[127:96];
  assign w5 = key_i[95:64];
  assign w6 = key_i[63:32];
  assign w7 = key_i[31:0];

  assign w3 = w7 ^ w6;
  assign w2 = w6 ^ w5;
  assign w1 = w5 ^ w4;

  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};

  // k_i was produced with Rcon[i+1]; out-of-range indices never occur in a
  // legal schedule but are forced to zero so the lookup stays in bounds.
  assign rcon_idx = rnd_i + 4'd1;
  assign rcon     = (rcon_idx >= 4'd1 && rcon_idx <= 4'd10) ? RCON[rcon_idx] : 8'h00;

  assign w0    = w4 ^ sub_w ^ {rcon, 24'h000000};
  assign key_o = {w0, w1, w2, w3};

  // Byte n sits at column n/4, row n%4; row r rotates right by r columns.
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_isr_isb
    localparam int COL = gi / 4;
    localparam int ROW = gi % 4;
    localparam int SRC = ((COL + 4 - ROW) % 4) * 4 + ROW;
    assign sb[127-8*gi -: 8] = INV_SBOX[state_i[127-8*SRC -: 8]];
  end

  assign ark = sb ^ key_o;

  for (gi = 0; gi < 4; gi++) begin : g_imc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*gi -: 8];
    assign a1 = ark[119-32*gi -: 8];
    assign a2 = ark[111-32*gi -: 8];
    assign a3 = ark[103-32*gi -: 8];
    assign mix[127-32*gi -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
    };
  end

  assign state_o = final_i ? ark : mix;

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decrypt core: accepts ciphertext plus the round-10 key,
// runs ROUNDS_PER_CYCLE chained inverse rounds per clock while rolling the
// key schedule backwards, then presents the plaintext until the sink takes it.
// Optional macro AES_DEC_KEY_REUSE_EN adds key_load and a saved-key register.
module aes_dec_iter
  import aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic           clk,
  input logic           rst,
  aes_dec_iter_if.slave bus
);

  if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
    $error("aes_dec_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  fsm_e       fsm_q, fsm_d;
  state_t     state_q, state_d;
  state_t     key_q, key_d;
  state_t     pt_q, pt_d;
  logic [3:0] rnd_q, rnd_d;
  state_t     accept_key;

  state_t chain_state [ROUNDS_PER_CYCLE+1];
  state_t chain_key   [ROUNDS_PER_CYCLE+1];

`ifdef AES_DEC_KEY_REUSE_EN
  state_t saved_key_q, saved_key_d;
  assign accept_key = bus.key_load ? bus.last_key : saved_key_q;
`else
  assign accept_key = bus.last_key;
`endif

  // Round chain: stage gi handles round rnd_q-gi; the round that reaches 0
  // drops InvMixColumns.
  assign chain_state[0] = state_q;
  assign chain_key[0]   = key_q;

  genvar gi;
  for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
    logic [3:0] idx;
    assign idx = rnd_q - 4'(gi);
    aes_inv_round u_round (
      .state_i (chain_state[gi]),
      .key_i   (chain_key[gi]),
      .rnd_i   (idx),
      .final_i (idx == 4'd0),
      .state_o (chain_state[gi+1]),
      .key_o   (chain_key[gi+1])
    );
  end

  // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    pt_d    = pt_q;
    rnd_d   = rnd_q;
`ifdef AES_DEC_KEY_REUSE_EN
    saved_key_d = saved_key_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.ciphertext ^ accept_key;
          key_d   = accept_key;
          rnd_d   = 4'd9;
          fsm_d   = RUN;
`ifdef AES_DEC_KEY_REUSE_EN
          if (bus.key_load) saved_key_d = bus.last_key;
`endif
        end
      end
      RUN: begin
        if (rnd_q == 4'(ROUNDS_PER_CYCLE - 1)) begin
          // This cycle's chain ends in round 0; rnd parks at 0.
          pt_d  = chain_state[ROUNDS_PER_CYCLE];
          rnd_d = 4'd0;
          fsm_d = DONE;
        end else begin
          state_d = chain_state[ROUNDS_PER_CYCLE];
          key_d   = chain_key[ROUNDS_PER_CYCLE];
          rnd_d   = rnd_q - 4'(ROUNDS_PER_CYCLE);
        end
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      rnd_q   <= 4'd0;
`ifdef AES_DEC_KEY_REUSE_EN
      saved_key_q <= '0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
`ifdef AES_DEC_KEY_REUSE_EN
      saved_key_q <= saved_key_d;
`endif
    end
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.busy      = (fsm_q != IDLE);
  assign bus.plaintext = pt_q;

endmodule

// File: doc/aes_dec_iter.md
# aes_dec_iter

Iterative AES-128 inverse-cipher engine that decrypts one 128-bit block per transaction. It computes ROUNDS_PER_CYCLE rounds per clock and derives each round key on the fly from the final (round-10) key. It replaces the fixed single-round registered decrypt stage with a self-sequencing, flow-controlled core. It sits between the ciphertext source and the plaintext sink, with valid/ready handshakes on both sides.

## Interface
- ROUNDS_PER_CYCLE, 1, rounds applied per RUN cycle; legal values are 1, 2, 5 and 10 (elaboration error otherwise).
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  ciphertext and key are valid.
- in_ready  output  1  core can accept a block.
- ciphertext  input  128  input block; [127:120] is FIPS byte 0, column-major.
- last_key  input  128  round-10 key (w[40..43]), same byte order.
- key_load  input  1  present only with AES_DEC_KEY_REUSE_EN (see Configuration).
- out_valid  output  1  plaintext is valid.
- out_ready  input  1  sink accepts plaintext.
- plaintext  output  128  decrypted block; held stable while out_valid && !out_ready.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: state_reg <= ciphertext ^ last_key, key_reg <= last_key, rnd <= 9, then go to RUN.
- RUN:
  - Each cycle applies ROUNDS_PER_CYCLE rounds combinationally, chained.
  - Each round first steps the key backwards (rnd → rnd-1) from the key it receives.
  - Round r = 9..1: InvShiftRows, InvSubBytes, AddRoundKey(k_r), InvMixColumns.
  - Round 0 (final): InvShiftRows, InvSubBytes, AddRoundKey(k_0); InvMixColumns is omitted.
  - rnd decrements by ROUNDS_PER_CYCLE per cycle. The cycle that completes round 0 loads plaintext and moves to DONE.
- Inverse key step, from k_{i+1} = (w4..w7) to k_i = (w0..w3):
  - w3 = w7^w6, w2 = w6^w5, w1 = w5^w4.
  - w0 = w4 ^ SubWord(RotWord(w3)) ^ Rcon[i+1].
  - Rcon sequence is 01,02,04,08,10,20,40,80,1b,36, placed in the MSB byte of the word.
- DONE:
  - out_valid = 1.
  - On out_ready: return to IDLE. in_ready stays 0 in that cycle, so a new accept happens no earlier than the following cycle.
- in_valid is ignored outside IDLE. ciphertext and last_key are sampled only on the accepting edge, so later changes have no effect.
- rst, at any state (including mid-RUN or in DONE with the sink stalled):
  - Next state is IDLE; in_ready = 1, out_valid = 0, busy = 0.
  - plaintext, state_reg, key_reg and rnd are cleared to 0.
  - The in-flight block is discarded; no partial output is emitted.
- All arithmetic is GF(2^8) with reduction polynomial 0x11b.
- rnd is 4 bits and never wraps below 0.

## Timing
- Accept at edge N leads to out_valid high from edge N + 10/ROUNDS_PER_CYCLE. Latency is therefore 10, 5, 2 or 1 cycles for R = 1, 2, 5, 10.
- Minimum period between accepts is 10/R + 2 cycles when out_ready is held high.
- All outputs are registered or pure FSM decodes; there is no combinational path from in_valid or out_ready to any output.
- Critical path grows linearly with ROUNDS_PER_CYCLE.

## Configuration
- AES_DEC_KEY_REUSE_EN defined:
  - Adds the key_load port and keeps a 128-bit saved_key register, reset to 0.
  - On an accept with key_load = 1: last_key is used and stored in saved_key.
  - On an accept with key_load = 0: saved_key is used and last_key is ignored.
- AES_DEC_KEY_REUSE_EN undefined:
  - No key_load port and no saved_key register.
  - last_key is used on every accept.

## Structure
- Package aes_pkg holds:
  - INV_SBOX and SBOX byte tables.
  - RCON array indexed 1..10.
  - xtime/gmul functions.
  - state_t (128-bit) and the ROUNDS_PER_CYCLE legality check.
- Sub-module aes_inv_round: combinational.
  - Inputs: state, key k_{i+1}, round index i, and a final-round flag.
  - Outputs: new state and k_i.
  - Instantiated ROUNDS_PER_CYCLE times in a generate chain.

## Test plan
- FIPS-197 C.1, R=1: ct 69c4e0d86a7b0430d8cdb78070b4c55a, last_key 13111d7fe3944a17f307a78b4d2b30c5 → plaintext 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept.
- FIPS-197 B, R=1/2/5/10 sweep: ct 3925841d02dc09fbdc118597196a0b32, last_key d014f9a8c9ee2589e13f0cc8b6630ca6 → plaintext 3243f6a8885a308d313198a2e0370734, latency 10/5/2/1.
- Backpressure: hold out_ready=0 for 20 cycles → plaintext stable, in_ready=0, second in_valid ignored; release → handshake, then next accept succeeds.
- Reset mid-RUN at round 5: assert rst one cycle → next cycle in_ready=1, out_valid=0, plaintext=0; the following C.1 transaction decrypts correctly.
- AES_DEC_KEY_REUSE_EN: first block key_load=1 with C.1 key, second block key_load=0 with last_key=0 and the C.1 ct → both produce 00112233445566778899aabbccddeeff.
- Back-to-back, out_ready tied 1: 8 random vectors checked against a reference model, accept spacing exactly 10/R+2 cycles.
